// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory that answers one held read/write
// request at a time. Each access goes IDLE -> WAIT (WAIT_CYCLES cycles)
// -> RESP, and ready_o is high for the single RESP cycle.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag accesses with
// addr[1:0] != 0. A flagged access completes with err_o=1, does not write
// memory, and leaves data_o unchanged.
module dmem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   mem_q [DEPTH];

    // Effective access: the live inputs on the capture edge, the captured
    // copy afterwards. With zero wait states the capture edge is also the
    // edge entering RESP, so the memory must see the live inputs there.
    logic [AW+1:0] eff_addr;
    logic [31:0]   eff_wdata;
    logic          eff_wr;
    logic [AW-1:0] eff_idx;
    logic          enter_resp;
    logic          misalign;
    logic          mem_we;

    // Upper address bits select nothing: addresses wrap modulo DEPTH words.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:AW+2], addr_q[1:0]};

    // Next-state, capture and memory-access decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        data_d     = data_q;
        eff_addr   = addr_q;
        eff_wdata  = wdata_q;
        eff_wr     = is_wr_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead_i || MemWrite_i) begin
                    // Both strobes high is a write.
                    addr_d    = addr_i[AW+1:0];
                    wdata_d   = data_i;
                    is_wr_d   = MemWrite_i;
                    eff_addr  = addr_i[AW+1:0];
                    eff_wdata = data_i;
                    eff_wr    = MemWrite_i;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        eff_idx = eff_addr[AW+1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = (eff_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        // Memory and read data update on the edge entering RESP.
        if (enter_resp && !misalign) begin
            if (eff_wr) mem_we = 1'b1;
            else        data_d = mem_q[eff_idx];
        end
    end

    // Control and capture registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            data_q  <= data_d;
        end
    end

    // Storage array; reset clears every word
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else if (mem_we) begin
            mem_q[eff_idx] <= eff_wdata;
        end
    end

    assign data_o  = data_q;
    assign ready_o = (state_q == RESP);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_o   = (state_q == RESP) && (addr_q[1:0] != 2'b00);
`else
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder. A word-array model
// predicts read data, err_o and completion latency (WAIT_CYCLES+1 cycles
// after the request edge). A second instance with zero wait states checks
// the shortest latency.
module tb_dmem_responder;
    localparam int W  = 2;
    localparam int D  = 128;
    localparam int D0 = 16;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rd, wr, rdy, err;
    logic [31:0] addr, wdata, rdata;
    logic        rd0, wr0, rdy0, err0;
    logic [31:0] addr0, wdata0, rdata0;

    dmem_responder #(.DEPTH(D), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr),
        .addr_i(addr), .data_i(wdata), .data_o(rdata), .ready_o(rdy), .err_o(err));

    dmem_responder #(.DEPTH(D0), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd0), .MemWrite_i(wr0),
        .addr_i(addr0), .data_i(wdata0), .data_o(rdata0), .ready_o(rdy0), .err_o(err0));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_m [D];
    logic [31:0] last_m;
    logic [31:0] mem0_m [D0];
    logic [31:0] last0_m;

    // One held access on the main instance, checked against the model.
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit perturb, input string tag);
        int idx, n;
        bit got, mis;
        logic [31:0] exp_data;
        idx = int'((a >> 2) & 32'(D - 1));
        mis = MIS && (a[1:0] != 2'b00);
        if (!mis) begin
            if (w) mem_m[idx] = d;
            else   last_m = mem_m[idx];
        end
        exp_data = last_m;
        rd = r; wr = w; addr = a; wdata = d;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rdy === 1'b1) got = 1;
            else begin
                vectors++;
                if (err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s err_idle: got %b want 0", tag, err);
                end
                if (perturb) begin addr = $urandom; wdata = $urandom; end
            end
        end
        vectors += 4;
        if (!got) begin
            miscompares += 4;
            $display("FAIL %s timeout: no ready_o within %0d cycles", tag, n);
        end else begin
            if (n != W + 1) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want %0d", tag, n, W + 1);
            end
            if (err !== mis) begin
                miscompares++;
                $display("FAIL %s err: got %b want %b", tag, err, mis);
            end
            if (rdata !== exp_data) begin
                miscompares++;
                $display("FAIL %s data: got %h want %h", tag, rdata, exp_data);
            end
            rd = 0; wr = 0;
            @(negedge clk);
            if (rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s ready_pulse: got %b want 0", tag, rdy);
            end
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < D; i++)  mem_m[i] = 32'd0;
        for (int i = 0; i < D0; i++) mem0_m[i] = 32'd0;
        last_m = 32'd0; last0_m = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        clear_models();
        repeat (3) @(negedge clk);
        vectors++;
        if ({rdy, err, rdata, rdy0, err0, rdata0} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b/%b/%h want 0/0/0", rdy, err, rdata);
        end
        rst_n = 1;
    endtask

    task automatic test_directed();
        access(1, 0, 32'h0, 32'h0, 0, "rd0_after_reset");
        access(0, 1, 32'h10, 32'hDEADBEEF, 0, "wr_10");
        access(1, 0, 32'h10, 32'h0, 0, "rd_10");
        access(1, 0, 32'h0, 32'h0, 0, "rd0_clear_last");
        access(0, 1, 32'h200, 32'h12345678, 1, "wr_200_wrap");
        access(1, 0, 32'h0, 32'h0, 1, "rd0_wrap");
        access(1, 1, 32'h8, 32'hA5A5A5A5, 0, "both_strobes");
        access(1, 0, 32'h8, 32'h0, 0, "rd_8");
        access(0, 1, 32'h6, 32'h11111111, 0, "wr_6_misaligned");
        access(1, 0, 32'h4, 32'h0, 0, "rd_4");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit r, w;
            a = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            r = 1'($urandom); w = 1'($urandom);
            if (!r && !w) r = 1;
            access(r, w, a, $urandom, 1'($urandom), "random");
        end
    endtask

    // Request held through ready_o starts a second access after one IDLE cycle.
    task automatic test_back_to_back();
        int n;
        bit got;
        logic [31:0] exp_data;
        access(0, 1, 32'h3C, 32'h0BADF00D, 0, "b2b_setup");
        exp_data = 32'h0BADF00D;
        last_m = exp_data;
        rd = 1; addr = 32'h3C;
        n = 0; got = 0;
        while (!got && n < 20) begin @(negedge clk); n++; got = (rdy === 1'b1); end
        n = 0; got = 0;
        while (!got && n < 20) begin @(negedge clk); n++; got = (rdy === 1'b1); end
        rd = 0;
        vectors += 2;
        if (!got || n != W + 2) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d want %0d", n, W + 2);
        end
        if (rdata !== exp_data) begin
            miscompares++;
            $display("FAIL b2b_data: got %h want %h", rdata, exp_data);
        end
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        access(0, 1, 32'h40, 32'h77777777, 0, "abort_setup");
        access(1, 0, 32'h40, 32'h0, 0, "abort_setup_rd");
        rd = 0; wr = 1; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(negedge clk);
        rst_n = 0; wr = 0;
        #1;
        vectors++;
        if ({rdy, rdata} !== 33'd0) begin
            miscompares++;
            $display("FAIL abort_reset_outputs: got %b/%h want 0/0", rdy, rdata);
        end
        @(negedge clk);
        rst_n = 1;
        clear_models();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_ready: got %b want 0", rdy);
            end
        end
        access(1, 0, 32'h20, 32'h0, 0, "abort_rd_20");
        access(0, 1, 32'h4, 32'h1, 0, "abort_wr_4");
        access(1, 0, 32'h40, 32'h0, 0, "abort_rd_40_cleared");
    endtask

    // Zero-wait instance: ready_o in the first cycle after the request edge.
    task automatic test_zero_wait();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, d, exp_data;
            bit w, mis;
            int idx, n;
            a = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 3)) << 2);
            if (i % 4 == 3) a[1:0] = 2'b10;
            d = $urandom; w = (i % 2 == 0);
            idx = int'((a >> 2) & 32'(D0 - 1));
            mis = MIS && (a[1:0] != 2'b00);
            if (!mis) begin
                if (w) mem0_m[idx] = d;
                else   last0_m = mem0_m[idx];
            end
            exp_data = last0_m;
            rd0 = !w; wr0 = w; addr0 = a; wdata0 = d;
            n = 0;
            do begin @(negedge clk); n++; end while (rdy0 !== 1'b1 && n < 10);
            rd0 = 0; wr0 = 0;
            vectors += 3;
            if (rdy0 !== 1'b1 || n != 1) begin
                miscompares++;
                $display("FAIL zw_latency: got %0d want 1", n);
            end
            if (rdata0 !== exp_data) begin
                miscompares++;
                $display("FAIL zw_data: got %h want %h", rdata0, exp_data);
            end
            if (err0 !== mis) begin
                miscompares++;
                $display("FAIL zw_err: got %b want %b", err0, mis);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_zero_wait();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
